// File: rtl/ahb_lite_arb2.sv
// ahb_lite_arb2: two-master AHB-Lite arbiter with per-master address buffers, burst lock and round-robin grant.
// Define ARB_FIXED_PRIO_EN to make M0 win every conflict instead of round-robin.
module ahb_lite_arb2 #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic [AW-1:0] m0_haddr,
    input  logic [1:0]    m0_htrans,
    input  logic          m0_hwrite,
    input  logic [2:0]    m0_hsize,
    input  logic [2:0]    m0_hburst,
    input  logic [DW-1:0] m0_hwdata,
    output logic          m0_hready,
    output logic          m0_hresp,
    output logic [DW-1:0] m0_hrdata,
    input  logic [AW-1:0] m1_haddr,
    input  logic [1:0]    m1_htrans,
    input  logic          m1_hwrite,
    input  logic [2:0]    m1_hsize,
    input  logic [2:0]    m1_hburst,
    input  logic [DW-1:0] m1_hwdata,
    output logic          m1_hready,
    output logic          m1_hresp,
    output logic [DW-1:0] m1_hrdata,
    output logic [AW-1:0] s_haddr,
    output logic [1:0]    s_htrans,
    output logic          s_hwrite,
    output logic [2:0]    s_hsize,
    output logic [2:0]    s_hburst,
    output logic [DW-1:0] s_hwdata,
    output logic          s_hready,
    input  logic          s_hreadyout,
    input  logic          s_hresp,
    input  logic [DW-1:0] s_hrdata
);
    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10;

    logic [1:0]    r_pend, r_write;
    logic [AW-1:0] r_addr [2];
    logic [1:0]    r_trans [2];
    logic [2:0]    r_size [2], r_burst [2];
    logic          r_owner, r_lock, r_dph_v, r_dph_id;
`ifndef ARB_FIXED_PRIO_EN
    logic          r_last;
`endif

    logic [AW-1:0] w_live_addr [2], w_src_addr [2];
    logic [1:0]    w_live_trans [2], w_src_trans [2];
    logic [2:0]    w_live_size [2], w_src_size [2], w_live_burst [2], w_src_burst [2];
    logic [1:0]    w_live_write, w_src_write, w_hready, w_hresp, w_req, w_take, w_cap;
    logic          w_lock_eff, w_pick, w_gnt;
    logic [1:0]    w_trans;

    assign w_live_addr[0]  = m0_haddr;
    assign w_live_addr[1]  = m1_haddr;
    assign w_live_trans[0] = m0_htrans;
    assign w_live_trans[1] = m1_htrans;
    assign w_live_size[0]  = m0_hsize;
    assign w_live_size[1]  = m1_hsize;
    assign w_live_burst[0] = m0_hburst;
    assign w_live_burst[1] = m1_hburst;
    assign w_live_write    = {m1_hwrite, m0_hwrite};

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_hready[n]    = (r_dph_v && r_dph_id == 1'(n)) ? s_hreadyout : !r_pend[n];
            w_hresp[n]     = r_dph_v && r_dph_id == 1'(n) && s_hresp;
            w_src_addr[n]  = r_pend[n] ? r_addr[n] : w_live_addr[n];
            w_src_trans[n] = r_pend[n] ? r_trans[n] : w_live_trans[n];
            w_src_size[n]  = r_pend[n] ? r_size[n] : w_live_size[n];
            w_src_burst[n] = r_pend[n] ? r_burst[n] : w_live_burst[n];
            w_src_write[n] = r_pend[n] ? r_write[n] : w_live_write[n];
            w_req[n]       = r_pend[n] || (w_live_trans[n][1] && w_hready[n]);
        end
        // Lock only holds while the owner continues its burst with SEQ/BUSY.
        w_lock_eff = r_lock && w_src_trans[r_owner][0];
`ifdef ARB_FIXED_PRIO_EN
        w_pick = !w_req[0];
`else
        w_pick = (&w_req) ? !r_last : w_req[1];
`endif
        w_gnt   = (!s_hreadyout || w_lock_eff || !(|w_req)) ? r_owner : w_pick;
        w_trans = (w_req[w_gnt] || w_lock_eff) ? w_src_trans[w_gnt] : IDLE;
        for (int n = 0; n < 2; n++) begin
            w_take[n] = s_hreadyout && w_gnt == 1'(n);
            w_cap[n]  = w_live_trans[n][1] && w_hready[n] && !w_take[n];
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            r_pend   <= '0;
            r_write  <= '0;
            r_owner  <= 1'b0;
            r_lock   <= 1'b0;
            r_dph_v  <= 1'b0;
            r_dph_id <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            r_last   <= 1'b1;
`endif
            for (int n = 0; n < 2; n++) begin
                r_addr[n]  <= '0;
                r_trans[n] <= IDLE;
                r_size[n]  <= '0;
                r_burst[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                r_pend[n] <= w_cap[n] || (r_pend[n] && !w_take[n]);
                if (w_cap[n]) begin
                    r_addr[n]  <= w_live_addr[n];
                    r_trans[n] <= w_live_trans[n];
                    r_size[n]  <= w_live_size[n];
                    r_burst[n] <= w_live_burst[n];
                    r_write[n] <= w_live_write[n];
                end
            end
            if (s_hreadyout) begin
                r_owner  <= w_gnt;
                r_dph_id <= w_gnt;
                r_dph_v  <= w_trans != IDLE;
                r_lock   <= (w_trans == NONSEQ && w_src_burst[w_gnt] != 3'b000) || w_lock_eff;
`ifndef ARB_FIXED_PRIO_EN
                r_last   <= w_trans[1] ? w_gnt : r_last;
`endif
            end
        end
    end

    assign s_haddr   = w_src_addr[w_gnt];
    assign s_htrans  = w_trans;
    assign s_hwrite  = w_src_write[w_gnt];
    assign s_hsize   = w_src_size[w_gnt];
    assign s_hburst  = w_src_burst[w_gnt];
    assign s_hwdata  = r_dph_id ? m1_hwdata : m0_hwdata;
    assign s_hready  = s_hreadyout;
    assign m0_hready = w_hready[0];
    assign m1_hready = w_hready[1];
    assign m0_hresp  = w_hresp[0];
    assign m1_hresp  = w_hresp[1];
    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;
endmodule
